mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH (default 32, address width) and DATA_WIDTH (default 32, data width; only 32 supported).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock; one clock, all state on posedge clk.
  rst_n  in  1  reset; asynchronous, active-low.
  flush  in  1  discard current or next access result.
  mem_enable_in  in  1  access request from EX/MEM register.
  mem_rw_in  in  1  1 = store, 0 = load.
  mem_width_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
  sign_extend_in  in  1  1 = sign-extend load, 0 = zero-extend.
  addr_in  in  ADDR_WIDTH  byte address (ALU result).
  write_data_in  in  DATA_WIDTH  store data, right-justified.
  stall_out  out  1  hold upstream pipeline.
  bus_req  out  1  bus request, held until bus_ack.
  bus_we  out  1  bus write enable.
  bus_addr  out  ADDR_WIDTH  word-aligned address, addr[1:0] forced to 00.
  bus_be  out  4  byte enables.
  bus_wdata  out  DATA_WIDTH  lane-replicated store data.
  bus_ack  in  1  bus completion, one-cycle pulse.
  bus_rdata  in  DATA_WIDTH  read word, valid with bus_ack.
  read_data_out  out  DATA_WIDTH  formatted load result.
  read_valid_out  out  1  one-cycle pulse; load result valid.
  misalign_out  out  1  one-cycle pulse; misaligned request.

Function
REQ-003 FSM SHALL have states IDLE, BUS, DONE.
REQ-004 IDLE: mem_enable_in=1 and flush=0 SHALL latch rw, width, sign, addr and data, then go to BUS. stall_out SHALL be 1 combinationally in that same cycle.
REQ-005 BUS: bus_req=1 and stall_out=1; bus_we/addr/be/wdata SHALL come from the latched request and stay stable until bus_ack.
REQ-006 BUS with bus_ack=1 SHALL register the formatted bus_rdata into read_data_out (loads only) and go to DONE.
REQ-007 DONE SHALL last exactly one cycle with stall_out=0 and bus_req=0. read_valid_out SHALL be 1 only for a load with no flush seen since latch. Next state is IDLE. A request present in DONE SHALL NOT be latched.
REQ-008 Minimum access latency SHALL be 3 cycles (IDLE, BUS, DONE), with bus_ack in the first BUS cycle.
REQ-009 Byte enables: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
REQ-010 bus_wdata: byte = {4{data[7:0]}}; half = {2{data[15:0]}}; word = data unchanged.
REQ-011 Load format: byte = bus_rdata[8*addr[1:0]+:8]; half = bus_rdata[16*addr[1]+:16]. Sign- or zero-extend to 32 bits per sign_extend.
REQ-012 Flush in IDLE SHALL suppress the latch. Flush in BUS SHALL NOT drop bus_req, because the transaction completes; read_valid_out SHALL then be suppressed in DONE.
REQ-013 read_data_out SHALL hold its value until the next completed load.

Reset
REQ-014 rst_n=0 SHALL force, asynchronously: state IDLE; bus_req, bus_we, read_valid_out and misalign_out to 0; bus_addr, bus_be, bus_wdata, read_data_out and all latched fields to 0.
REQ-015 Reset during BUS SHALL abandon the transaction. A bus_ack arriving after reset in IDLE SHALL be ignored.

Configuration
REQ-016 Macro MEM_ALIGN_CHECK_EN, when defined, SHALL treat these requests as misaligned: half with addr[0]=1, and word with addr[1:0]!=00.
REQ-017 A misaligned request SHALL go IDLE->DONE with no bus_req. In DONE, misalign_out=1 and read_valid_out=0.
REQ-018 Without MEM_ALIGN_CHECK_EN, misalign_out SHALL be tied 0 and misaligned low address bits SHALL be ignored per REQ-009/011.

Verification
REQ-019 Word load, addr=0x100, ack in 1st BUS cycle, rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, read_data_out=0xDEADBEEF, valid pulse in cycle 3.
REQ-020 Signed byte load, addr=0x103, rdata=0x80112233 -> be=1000, read_data_out=0xFFFFFF80; with sign_extend=0 -> 0x00000080.
REQ-021 Half store, addr=0x202, data=0x0000ABCD, ack after 4 BUS cycles -> we=1, be=1100, wdata=0xABCDABCD, stall_out high 5 cycles, no read_valid.
REQ-022 Load with flush in 2nd BUS cycle -> bus_req held until ack, read_valid_out stays 0, read_data_out updated.
REQ-023 rst_n low mid-BUS, late ack after release -> bus_req=0 immediately, state IDLE, no read_valid.
REQ-024 MEM_ALIGN_CHECK_EN defined, word load addr=0x101 -> no bus_req, misalign_out pulse 1 cycle after request; undefined -> bus_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging the EX/MEM stage to a single-beat request/ack bus.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word requests instead of issuing them.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  mem_enable_in,
    input  logic                  mem_rw_in,
    input  logic [1:0]            mem_width_in,
    input  logic                  sign_extend_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    output logic                  stall_out,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic                  read_valid_out,
    output logic                  misalign_out
);
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t                state_q, state_d;
    logic                  rw_q, rw_d, sign_q, sign_d, flushed_q, flushed_d, mis_q, mis_d;
    logic [1:0]            width_q, width_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d;
    logic                  accept, mis_req;
    logic [7:0]            lb;
    logic [15:0]           lh;
    logic [DATA_WIDTH-1:0] load_fmt, wdata_fmt;
    logic [3:0]            be_fmt;

    assign accept   = (state_q == IDLE) & mem_enable_in & ~flush;
    assign mis_req  = ALIGN_EN & (((mem_width_in == 2'b01) & addr_in[0]) | (mem_width_in[1] & |addr_in[1:0]));

    // Store data is lane-replicated once at latch time so the bus sees it directly.
    assign wdata_fmt = (mem_width_in == 2'b00) ? {4{write_data_in[7:0]}} :
                       (mem_width_in == 2'b01) ? {2{write_data_in[15:0]}} : write_data_in;
    assign be_fmt    = (width_q == 2'b00) ? 4'b0001 << addr_q[1:0] :
                       (width_q == 2'b01) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign lb       = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lh       = bus_rdata[{addr_q[1], 4'b0000} +: 16];
    assign load_fmt = (width_q == 2'b00) ? {{24{sign_q & lb[7]}}, lb} :
                      (width_q == 2'b01) ? {{16{sign_q & lh[15]}}, lh} : bus_rdata;

    assign bus_req        = state_q == BUS;
    assign bus_we         = bus_req & rw_q;
    assign bus_be         = bus_req ? be_fmt : 4'b0000;
    assign bus_addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_wdata      = data_q;
    assign stall_out      = accept | bus_req;
    assign read_data_out  = rdata_q;
    assign read_valid_out = (state_q == DONE) & ~rw_q & ~flushed_q & ~mis_q & ~flush;
    assign misalign_out   = ALIGN_EN & (state_q == DONE) & mis_q;

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        sign_d    = sign_q;
        width_d   = width_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        flushed_d = flushed_q;
        mis_d     = mis_q;
        case (state_q)
            IDLE: if (accept) begin
                rw_d      = mem_rw_in;
                sign_d    = sign_extend_in;
                width_d   = mem_width_in;
                addr_d    = addr_in;
                data_d    = wdata_fmt;
                flushed_d = 1'b0;
                mis_d     = mis_req;
                state_d   = mis_req ? DONE : BUS;
            end
            BUS: begin
                flushed_d = flushed_q | flush;
                rdata_d   = (bus_ack & ~rw_q) ? load_fmt : rdata_q;
                state_d   = bus_ack ? DONE : BUS;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            sign_q    <= 1'b0;
            width_q   <= 2'b00;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            flushed_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            sign_q    <= sign_d;
            width_q   <= width_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            flushed_q <= flushed_d;
            mis_q     <= mis_d;
        end
    end
endmodule
